// File: rtl/hkspi_pkg.sv
// ---------------------------------------------------------------------------
// hkspi_pkg
// Shared definitions for the housekeeping-SPI register-access sequencer:
//   CMD_WR / CMD_RD  : command bytes for stream write / stream read
//   FRAME_BITS       : length of one {cmd, addr, data} frame in bits
//   LAST_BIT_IDX     : starting value of the down-counting bit index
//   hk_state_e       : sequencer state encoding
//   build_frame()    : assembles the 24-bit frame for one request
// ---------------------------------------------------------------------------
package hkspi_pkg;

  localparam logic [7:0] CMD_WR = 8'h80;
  localparam logic [7:0] CMD_RD = 8'h40;

  localparam int         FRAME_BITS   = 24;
  localparam logic [4:0] LAST_BIT_IDX = 5'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } hk_state_e;

  // Reads carry a dummy 0x00 byte in the data slot so the target can clock
  // its reply out while we shift it.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic       wr,
    input logic [7:0] addr,
    input logic [7:0] wdata
  );
    if (wr)
      build_frame = {CMD_WR, addr, wdata};
    else
      build_frame = {CMD_RD, addr, 8'h00};
  endfunction

endpackage

// File: rtl/hkspi_halfper_cnt.sv
// ---------------------------------------------------------------------------
// hkspi_halfper_cnt
// Half-period timer for the SPI sequencer. While enabled it counts
// 0..CLK_DIV-1 and wraps, raising tick during the last cycle of each
// CLK_DIV-cycle phase. Held at zero while disabled so every frame starts
// phase-aligned.
// Ports:
//   line_clk      in   system clock
//   line_reset_n  in   asynchronous active-low reset
//   en            in   count enable (high while a frame is in progress)
//   tick          out  one-cycle pulse marking the final cycle of a phase
// ---------------------------------------------------------------------------
module hkspi_halfper_cnt
  import hkspi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic line_clk,
  input  logic line_reset_n,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] CNT_LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  always_ff @(posedge line_clk or negedge line_reset_n) begin
    if (!line_reset_n) begin
      cnt <= 8'h00;
    end else if (!en || (cnt == CNT_LAST)) begin
      cnt <= 8'h00;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tick = en && (cnt == CNT_LAST);

endmodule

// File: rtl/hkspi_seq.sv
// ---------------------------------------------------------------------------
// hkspi_seq
// Single-register read/write sequencer for the Caravel housekeeping SPI.
// A request accepted on the valid/ready handshake is turned into one SPI
// mode-0 stream frame {cmd, addr, data/dummy}, MSB first. When the frame
// completes a one-cycle rsp_valid pulse returns the read byte (0x00 for
// writes). Frame timeline in units of CLK_DIV cycles:
//   SETUP 1 | SHIFT 24 x (high 1 + low 1) | HOLD 1 | GAP 2  = 52
// Ports:
//   line_clk      in   system clock
//   line_reset_n  in   asynchronous active-low reset
//   req_valid     in   request present
//   req_ready     out  sequencer idle and able to accept
//   req_wr        in   1 = write, 0 = read
//   req_addr      in   housekeeping register address
//   req_wdata     in   write data (ignored for reads)
//   rsp_valid     out  one-cycle completion pulse
//   rsp_rd        out  completed transaction was a read
//   rsp_data      out  read data, 0x00 after writes
//   busy          out  transaction in progress
//   spi_sck       out  SPI clock, idle low
//   spi_csn       out  chip select, active low
//   spi_mosi      out  serial data to target
//   spi_miso      in   serial data from target
// ---------------------------------------------------------------------------
module hkspi_seq
  import hkspi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       line_clk,
  input  logic       line_reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wr,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic       rsp_rd,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       spi_sck,
  output logic       spi_csn,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  generate
    if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
      $error("hkspi_seq: CLK_DIV must be within 2..255");
    end
  endgenerate

  hk_state_e             state;
  hk_state_e             state_nxt;
  logic                  tick;
  logic [FRAME_BITS-1:0] shreg;
  logic [7:0]            rx;
  logic [4:0]            bit_cnt;
  logic                  sck_hi;
  logic                  gap_second;
  logic                  is_rd;

  // One timer serves every phase; all phases are whole multiples of
  // CLK_DIV, so it runs free from the start of SETUP to the end of GAP.
  hkspi_halfper_cnt #(
    .CLK_DIV (CLK_DIV)
  ) u_halfper_cnt (
    .line_clk     (line_clk),
    .line_reset_n (line_reset_n),
    .en           (state != IDLE),
    .tick         (tick)
  );

  // State register
  always_ff @(posedge line_clk or negedge line_reset_n) begin
    if (!line_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) state_nxt = SETUP;
      end
      SETUP: begin
        if (tick) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (tick && !sck_hi && (bit_cnt == 5'd0)) state_nxt = HOLD;
      end
      HOLD: begin
        if (tick) state_nxt = GAP;
      end
      GAP: begin
        if (tick && gap_second) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame datapath and response registers
  always_ff @(posedge line_clk or negedge line_reset_n) begin
    if (!line_reset_n) begin
      shreg      <= '0;
      rx         <= 8'h00;
      bit_cnt    <= 5'd0;
      sck_hi     <= 1'b0;
      gap_second <= 1'b0;
      is_rd      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rd     <= 1'b0;
      rsp_data   <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            shreg      <= build_frame(req_wr, req_addr, req_wdata);
            is_rd      <= !req_wr;
            bit_cnt    <= LAST_BIT_IDX;
            sck_hi     <= 1'b0;
            gap_second <= 1'b0;
          end
        end
        SETUP: begin
          if (tick) sck_hi <= 1'b1;
        end
        SHIFT: begin
          if (tick) begin
            if (sck_hi) begin
              // End of high phase: sample the target, and shift so the next
              // bit appears on mosi in the first low-phase cycle.
              rx     <= {rx[6:0], spi_miso};
              shreg  <= {shreg[FRAME_BITS-2:0], 1'b0};
              sck_hi <= 1'b0;
            end else if (bit_cnt != 5'd0) begin
              bit_cnt <= bit_cnt - 5'd1;
              sck_hi  <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            rsp_valid <= 1'b1;
            rsp_rd    <= is_rd;
            rsp_data  <= is_rd ? rx : 8'h00;
          end
        end
        GAP: begin
          if (tick) gap_second <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode. Pins come straight from reset-cleared registers, so an
  // asserted reset releases csn and drops sck without waiting for a clock.
  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b1;
    spi_csn   = 1'b1;
    spi_sck   = 1'b0;
    spi_mosi  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      SETUP, HOLD: begin
        spi_csn  = 1'b0;
        spi_mosi = shreg[FRAME_BITS-1];
      end
      SHIFT: begin
        spi_csn  = 1'b0;
        spi_sck  = sck_hi;
        spi_mosi = shreg[FRAME_BITS-1];
      end
      default: begin
      end
    endcase
  end

endmodule
